pc_unit: RTL
============

// Module: pc_unit
// PURPOSE
//  Program-counter stage of the 16-bit MIPS datapath. Holds the current PC and drives pc_plus_inc
//  into the next-PC 2:1 mux (input0). Branch targets arrive on that mux's input1; its output is
//  latched back here on next_pc. Adds stall/halt control and a one-cycle wrong-path flush toward IF/ID.
// PARAMETERS
//  WIDTH     16       PC width in bits
//  RESET_PC  16'h0000 PC value loaded on reset
//  INC       1        increment per sequential fetch (word addressed)
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous active-low reset
//  next_pc      in   WIDTH  next-PC mux output
//  redirect     in   1      branch/jump taken; same signal drives next-PC mux select
//  stall        in   1      hazard stall: hold PC
//  halt_req     in   1      request halt (level)
//  resume       in   1      leave HALT (level)
//  pc           out  WIDTH  current fetch address (registered)
//  pc_plus_inc  out  WIDTH  pc + INC, combinational, to mux input0
//  fetch_valid  out  1      pc is a live fetch this cycle (registered)
//  flush        out  1      kill instruction in IF/ID (registered, 1-cycle pulse)
//  halted       out  1      FSM in HALT (registered)
// BEHAVIOUR
//  Reset (rst_n=0, async): pc=RESET_PC, fetch_valid=0, flush=0, halted=0, state=BOOT.
//  FSM states: BOOT, RUN, STALL, HALT. All outputs except pc_plus_inc update on clk rising edge.
//  BOOT: one cycle after rst_n rises -> RUN; pc held at RESET_PC; fetch_valid=1 from the first RUN cycle.
//  RUN priority per cycle: halt_req > stall > advance.
//   halt_req=1 -> HALT; pc holds; fetch_valid<=0; halted<=1; flush<=0.
//   stall=1    -> STALL; pc holds; fetch_valid<=0; flush<=0; redirect ignored this cycle.
//   else       -> pc<=next_pc; fetch_valid<=1; flush<=redirect.
//  STALL: same priority; stall=0 and halt_req=0 -> RUN with advance rule applied that cycle.
//  HALT: pc holds; halted=1; fetch_valid=0; resume=1 and halt_req=0 -> RUN (halted<=0, no pc change
//   that cycle); resume and halt_req both 1 -> stay HALT.
//  flush never asserts two consecutive cycles unless redirect is accepted two consecutive cycles.
//  pc_plus_inc = (pc + INC) mod 2^WIDTH; 16'hFFFF + 1 -> 16'h0000, no carry out, no error.
//  next_pc taken as-is (no alignment check); pc updates only on accepted advance.
//  rst_n asserted mid-operation (any state): immediate return to reset values regardless of clk.
//  No X propagation: unknown inputs in BOOT/HALT must not change pc.
// CONFIGURATION
//  PC_REDIRECT_CNT_EN defined: adds port redirect_cnt out 16; counts accepted redirects (RUN/STALL
//   advance cycles with redirect=1); saturates at 16'hFFFF; reset 0; unaffected by HALT.
//  Not defined: port and counter absent; all other behaviour identical.
// TESTING
//  Reset, release, stall=0, redirect=0, next_pc=pc_plus_inc -> BOOT 1 cycle, then pc 0000,0001,0002; fetch_valid 1.
//  pc=16'h0010, redirect=1, next_pc=16'h0040 -> next cycle pc=0040, flush=1 for exactly one cycle.
//  stall=1 for 3 cycles with redirect=1 at pc=0005 -> pc stays 0005, fetch_valid=0, flush=0, no count.
//  halt_req=1 at pc=0020, then halt_req=0 & resume=1 -> halted=1, pc=0020 held; RUN next, halted=0.
//  pc=16'hFFFF sequential advance -> pc_plus_inc=0000, next pc=0000; rst_n low mid-stall -> pc=RESET_PC at once.
//  PC_REDIRECT_CNT_EN: 3 accepted redirects + 1 stalled -> redirect_cnt=3; preload to FFFF -> holds FFFF.

Source files
------------

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit
// Description : Program-counter stage of the 16-bit MIPS datapath. It holds
//               the fetch PC and handles boot, stall, halt and wrong-path
//               flush toward IF/ID.
// Options     : PC_REDIRECT_CNT_EN adds a saturating count of accepted
//               redirects on port redirect_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_unit #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] INC      = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] next_pc,
  input  logic             redirect,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             resume,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_inc,
  output logic             fetch_valid,
  output logic             flush,
  output logic             halted
`ifdef PC_REDIRECT_CNT_EN
  ,
  output logic [15:0]      redirect_cnt
`endif
);

  localparam logic [1:0] c_st_boot  = 2'd0;
  localparam logic [1:0] c_st_run   = 2'd1;
  localparam logic [1:0] c_st_stall = 2'd2;
  localparam logic [1:0] c_st_halt  = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] w_pc_nxt;
  logic             w_fetch_valid_nxt;
  logic             w_flush_nxt;
  logic             w_halted_nxt;
  logic             w_redirect_acc;

  assign pc_plus_inc = pc + INC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_boot;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // RUN and STALL share one decision: halt_req beats stall beats advance.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_boot: w_state_nxt = c_st_run;
      c_st_run, c_st_stall: begin
        if (halt_req) begin
          w_state_nxt = c_st_halt;
        end else if (stall) begin
          w_state_nxt = c_st_stall;
        end else begin
          w_state_nxt = c_st_run;
        end
      end
      c_st_halt: begin
        if (resume && !halt_req) begin
          w_state_nxt = c_st_run;
        end
      end
      default: w_state_nxt = c_st_boot;
    endcase
  end

  // Only an accepted advance ever loads next_pc, so BOOT/HALT never see it.
  always_comb begin
    w_pc_nxt          = pc;
    w_fetch_valid_nxt = 1'b0;
    w_flush_nxt       = 1'b0;
    w_halted_nxt      = halted;
    w_redirect_acc    = 1'b0;
    case (r_state)
      c_st_boot: begin
        w_fetch_valid_nxt = 1'b1;
        w_halted_nxt      = 1'b0;
      end
      c_st_run, c_st_stall: begin
        if (halt_req) begin
          w_halted_nxt = 1'b1;
        end else if (!stall) begin
          w_pc_nxt          = next_pc;
          w_fetch_valid_nxt = 1'b1;
          w_flush_nxt       = redirect;
          w_redirect_acc    = redirect;
        end
      end
      c_st_halt: begin
        w_halted_nxt = 1'b1;
        if (resume && !halt_req) begin
          w_halted_nxt      = 1'b0;
          w_fetch_valid_nxt = 1'b1;
        end
      end
      default: begin
        w_halted_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      fetch_valid <= 1'b0;
      flush       <= 1'b0;
      halted      <= 1'b0;
    end else begin
      pc          <= w_pc_nxt;
      fetch_valid <= w_fetch_valid_nxt;
      flush       <= w_flush_nxt;
      halted      <= w_halted_nxt;
    end
  end

`ifdef PC_REDIRECT_CNT_EN
  logic [15:0] r_redirect_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redirect_cnt <= 16'h0000;
    end else if (w_redirect_acc && (r_redirect_cnt != 16'hFFFF)) begin
      r_redirect_cnt <= r_redirect_cnt + 16'd1;
    end
  end

  assign redirect_cnt = r_redirect_cnt;
`else
  logic w_unused_redirect_acc;
  assign w_unused_redirect_acc = w_redirect_acc;
`endif

endmodule
`default_nettype wire
